instr_loader: RTL

Program-load and run-control front end for the MIPS pipeline. Receives a byte stream from the debug link (UART RX side), assembles big-endian 32-bit instruction words, and drives the pipeline's instruction-memory write port (`i_we_IF` / `i_instruction_data`). After loading it pulses the pipeline reset to start execution, then converts run-time command bytes into the pipeline's `i_halt` input.

---
 rtl/instr_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Program-load and run-control front end for the MIPS pipeline. Bytes from the
// debug link are assembled MSB-first into instruction words and written into
// the pipeline's instruction memory through an auto-incrementing write port.
// Once the program is in, the pipeline reset is released and run-time command
// bytes drive the pipeline halt input.
//
// Ports:
//   clk                 single clock
//   i_rst_n             synchronous active-low reset
//   i_rx_data           stream byte
//   i_rx_valid          one-cycle strobe, byte taken on every edge it is high
//   o_we_IF             registered instruction-memory write strobe
//   o_instruction_data  word being written (holds until the next word)
//   o_cpu_rst_n         active-low pipeline reset (high only while running)
//   o_halt              pipeline halt
//   o_instr_count       words written during the current load
//   o_loading           high while loading
//   o_running           high while running
//   o_error             sticky empty-program flag
//
// NB_DATA must be an integer multiple (>= 2) of NB_BYTE.
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int                 NB_DATA    = 32,
    parameter int                 NB_BYTE    = 8,
    parameter int                 MAX_INSTR  = 64,
    parameter logic [NB_DATA-1:0] END_WORD   = {NB_DATA{1'b1}},
    parameter logic [NB_BYTE-1:0] CMD_LOAD   = 8'h4C,
    parameter logic [NB_BYTE-1:0] CMD_HALT   = 8'h48,
    parameter logic [NB_BYTE-1:0] CMD_RESUME = 8'h52
) (
    input  logic                           clk,
    input  logic                           i_rst_n,
    input  logic [NB_BYTE-1:0]             i_rx_data,
    input  logic                           i_rx_valid,
    output logic                           o_we_IF,
    output logic [NB_DATA-1:0]             o_instruction_data,
    output logic                           o_cpu_rst_n,
    output logic                           o_halt,
    output logic [$clog2(MAX_INSTR+1)-1:0] o_instr_count,
    output logic                           o_loading,
    output logic                           o_running,
    output logic                           o_error
);

    localparam int BYTES = NB_DATA / NB_BYTE;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CW    = $clog2(MAX_INSTR + 1);
    localparam int ASW   = NB_DATA - NB_BYTE;   // bytes held before the last one arrives

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_INSTR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN
    } state_t;

    state_t             state_reg,    state_next;
    logic [BCW-1:0]     byte_cnt_reg, byte_cnt_next;
    logic [ASW-1:0]     asm_reg,      asm_next;
    logic               we_reg,       we_next;
    logic [NB_DATA-1:0] data_reg,     data_next;
    logic               halt_reg,     halt_next;
    logic [CW-1:0]      count_reg,    count_next;
    logic               error_reg,    error_next;

    // Word as it would look if the current byte completes it.
    logic [NB_DATA-1:0] word_in;
    assign word_in = {asm_reg, i_rx_data};

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= '0;
            asm_reg      <= '0;
            we_reg       <= 1'b0;
            data_reg     <= '0;
            halt_reg     <= 1'b0;
            count_reg    <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            asm_reg      <= asm_next;
            we_reg       <= we_next;
            data_reg     <= data_next;
            halt_reg     <= halt_next;
            count_reg    <= count_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        asm_next      = asm_reg;
        we_next       = 1'b0;
        data_next     = data_reg;
        halt_next     = halt_reg;
        count_next    = count_reg;
        error_next    = error_reg;

        case (state_reg)
            ST_IDLE: begin
                if (i_rx_valid && i_rx_data == CMD_LOAD) begin
                    state_next    = ST_LOAD;
                    byte_cnt_next = '0;
                    count_next    = '0;
                    error_next    = 1'b0;
                end
            end

            ST_LOAD: begin
                // A full memory needs no terminator: the cycle after the last
                // strobe moves on to START and any byte arriving then is dropped.
                if (count_reg == MAX_CNT) begin
                    state_next = ST_START;
                end else if (i_rx_valid) begin
                    if (byte_cnt_reg == LAST_BYTE) begin
                        byte_cnt_next = '0;
                        if (word_in == END_WORD) begin
                            if (count_reg == '0) begin
                                error_next = 1'b1;
                                state_next = ST_IDLE;
                            end else begin
                                state_next = ST_START;
                            end
                        end else begin
                            we_next    = 1'b1;
                            data_next  = word_in;
                            count_next = count_reg + CW'(1);
                        end
                    end else begin
                        byte_cnt_next = byte_cnt_reg + BCW'(1);
                        asm_next      = word_in[ASW-1:0];
                    end
                end
            end

            ST_START: begin
                // Single cycle of pipeline reset after loading; bytes are dropped.
                state_next = ST_RUN;
            end

            ST_RUN: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_HALT) begin
                        halt_next = 1'b1;
                    end else if (i_rx_data == CMD_RESUME) begin
                        halt_next = 1'b0;
                    end else if (i_rx_data == CMD_LOAD) begin
                        halt_next     = 1'b0;
                        state_next    = ST_LOAD;
                        byte_cnt_next = '0;
                        count_next    = '0;
                        error_next    = 1'b0;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The pipeline is held in reset everywhere except RUN, so the reset pulse
    // on START and the drop on a reload both fall out of the state register.
    assign o_cpu_rst_n        = (state_reg == ST_RUN);
    assign o_running          = (state_reg == ST_RUN);
    assign o_loading          = (state_reg == ST_LOAD);
    assign o_we_IF            = we_reg;
    assign o_instruction_data = data_reg;
    assign o_halt             = halt_reg;
    assign o_instr_count      = count_reg;
    assign o_error            = error_reg;

endmodule
